// File: rtl/sneva_pkg.sv
// Shared constants and the queued writeback entry type.
package sneva_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback queue: up to two pushes and one pop per cycle.
// Slot 0 is always written before slot 1. The caller keeps occupancy within
// 0..DEPTH. Per-slot rd and valid vectors feed the pending-write lookup.
module wb_fifo
  import sneva_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push0,
  input  wb_entry_t                i_ent0,
  input  logic                     i_push1,
  input  wb_entry_t                i_ent1,
  input  logic                     i_pop,
  output wb_entry_t                o_head,
  output logic [CW-1:0]            o_count,
  output logic [DEPTH-1:0]         o_valid,
  output logic [DEPTH-1:0][AW-1:0] o_rd
);

  wb_entry_t         r_mem [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     w_wptr1;
  logic [PW-1:0]     w_wptr_nxt;
  logic [PW-1:0]     w_off;

  assign w_wptr1 = r_wptr + PW'(1);

  // Next write pointer advances by the number of pushes this cycle.
  always_comb begin
    w_wptr_nxt = r_wptr;
    if (i_push0 && i_push1)
      w_wptr_nxt = r_wptr + PW'(2);
    else if (i_push0 || i_push1)
      w_wptr_nxt = w_wptr1;
  end

  // Storage array; the second entry lands behind the first when both push.
  always_ff @(posedge i_clk) begin
    if (i_push0)
      r_mem[r_wptr] <= i_ent0;
    if (i_push1)
      r_mem[i_push0 ? w_wptr1 : r_wptr] <= i_ent1;
  end

  // Pointers and occupancy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      if (i_pop)
        r_rptr <= r_rptr + PW'(1);
      r_count <= r_count + CW'(i_push0) + CW'(i_push1) - CW'(i_pop);
    end
  end

  // A slot is valid when its distance from the read pointer is below the count.
  always_comb begin
    o_valid = '0;
    o_rd    = '0;
    w_off   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_off      = PW'(i) - r_rptr;
      o_valid[i] = ({1'b0, w_off} < r_count);
      o_rd[i]    = r_mem[i].rd;
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/wb_ctrl.sv
// Writeback controller: accepts LSU/ALU results, queues them in order,
// drains one per cycle into the register bank write port, drops r0 writes
// and answers decode hazard queries.
module wb_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = sneva_pkg::XLEN,
  parameter int unsigned AW    = sneva_pkg::AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lsu_valid,
  output logic                   lsu_ready,
  input  logic [AW-1:0]          lsu_rd,
  input  logic [XLEN-1:0]        lsu_data,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [AW-1:0]          alu_rd,
  input  logic [XLEN-1:0]        alu_data,
  input  logic                   rf_busy,
  output logic                   reg_wen,
  output logic [AW-1:0]          reg_waddr,
  output logic [XLEN-1:0]        reg_wdata,
  input  logic [AW-1:0]          chk_addr,
  output logic                   chk_pending,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

  sneva_pkg::wb_entry_t     w_ent0;
  sneva_pkg::wb_entry_t     w_ent1;
  sneva_pkg::wb_entry_t     w_head;
  logic [CW-1:0]            w_count;
  logic [DEPTH-1:0]         w_valid;
  logic [DEPTH-1:0][AW-1:0] w_rd;
  logic                     w_lsu_ready;
  logic                     w_alu_ready;
  logic                     w_push0;
  logic                     w_push1;
  logic                     w_pop;
  logic                     w_hit;
  logic                     r_wen;
  logic [AW-1:0]            r_waddr;
  logic [XLEN-1:0]          r_wdata;

  // Readiness uses only the registered count; the last free slot goes to the LSU.
  assign w_lsu_ready = !rst && (w_count < FULL_CNT);
  assign w_alu_ready = !rst && ((w_count < LAST_CNT) ||
                                ((w_count == LAST_CNT) && !lsu_valid));

  // r0 results complete the handshake but never enter the queue.
  assign w_push0 = lsu_valid && w_lsu_ready && (lsu_rd != '0);
  assign w_push1 = alu_valid && w_alu_ready && (alu_rd != '0);
  assign w_pop   = (w_count != '0) && !rf_busy;

  assign w_ent0 = '{rd: lsu_rd, data: lsu_data};
  assign w_ent1 = '{rd: alu_rd, data: alu_data};

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push0 (w_push0),
    .i_ent0  (w_ent0),
    .i_push1 (w_push1),
    .i_ent1  (w_ent1),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count),
    .o_valid (w_valid),
    .o_rd    (w_rd)
  );

  // Bank write port register: pulse low for one cycle per popped entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wen   <= 1'b1;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_pop) begin
      r_wen   <= 1'b0;
      r_waddr <= w_head.rd;
      r_wdata <= w_head.data;
    end else begin
      r_wen   <= 1'b1;
    end
  end

  // Hazard lookup over queued entries plus the write currently on the port.
  always_comb begin
    w_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && (w_rd[i] == chk_addr))
        w_hit = 1'b1;
    end
  end

  assign chk_pending = (chk_addr != '0) &&
                       (w_hit || (!r_wen && (r_waddr == chk_addr)));

  assign lsu_ready = w_lsu_ready;
  assign alu_ready = w_alu_ready;
  assign reg_wen   = r_wen;
  assign reg_waddr = r_waddr;
  assign reg_wdata = r_wdata;
  assign q_count   = w_count;

endmodule

// File: tb/tb_wb_ctrl.sv
// Bench for wb_ctrl: vector table plus hand-written corner sequences, with a
// queue scoreboard checking ready, occupancy, bank writes and hazard lookup.
module tb_wb_ctrl;

  logic        clk;
  logic        rst;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        rf_busy;
  logic        reg_wen;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic [4:0]  chk_addr;
  logic        chk_pending;
  logic [2:0]  q_count;

  int n_chk  = 0;
  int n_fail = 0;

  wb_ctrl #(
    .DEPTH (4),
    .XLEN  (32),
    .AW    (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .rf_busy     (rf_busy),
    .reg_wen     (reg_wen),
    .reg_waddr   (reg_waddr),
    .reg_wdata   (reg_wdata),
    .chk_addr    (chk_addr),
    .chk_pending (chk_pending),
    .q_count     (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Scoreboard: expected bank writes in acceptance order.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        sb[$];
  ent_t        m_e;
  logic        m_wen  = 1'b1;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  bit          m_lr;
  bit          m_ar;

  // Reference queue updated on each rising edge from bench-driven inputs.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        sb.delete();
        m_wen  = 1'b1;
        m_addr = '0;
        m_data = '0;
      end else begin
        m_lr = (sb.size() < 4);
        m_ar = (sb.size() < 3) || ((sb.size() == 3) && !lsu_valid);
        if ((sb.size() > 0) && !rf_busy) begin
          m_e    = sb.pop_front();
          m_wen  = 1'b0;
          m_addr = m_e.rd;
          m_data = m_e.data;
        end else begin
          m_wen = 1'b1;
        end
        if (lsu_valid && m_lr && (lsu_rd != 0)) sb.push_back('{lsu_rd, lsu_data});
        if (alu_valid && m_ar && (alu_rd != 0)) sb.push_back('{alu_rd, alu_data});
      end
    end
  end

  // Every falling edge: compare all outputs with the reference.
  bit e_lr, e_ar, e_pend;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("sb_lsu_ready_rst", lsu_ready, 0);
        chk("sb_alu_ready_rst", alu_ready, 0);
        chk("sb_count_rst", q_count, 0);
        chk("sb_wen_rst", reg_wen, 1);
        chk("sb_waddr_rst", reg_waddr, 0);
        chk("sb_wdata_rst", reg_wdata, 0);
      end else begin
        e_lr   = (sb.size() < 4);
        e_ar   = (sb.size() < 3) || ((sb.size() == 3) && !lsu_valid);
        e_pend = 1'b0;
        foreach (sb[k]) if (sb[k].rd == chk_addr) e_pend = 1'b1;
        if (!m_wen && (m_addr == chk_addr)) e_pend = 1'b1;
        if (chk_addr == 0) e_pend = 1'b0;
        chk("sb_lsu_ready", lsu_ready, e_lr);
        chk("sb_alu_ready", alu_ready, e_ar);
        chk("sb_count", q_count, sb.size());
        chk("sb_wen", reg_wen, m_wen);
        chk("sb_pending", chk_pending, e_pend);
        if (!m_wen) begin
          chk("sb_waddr", reg_waddr, m_addr);
          chk("sb_wdata", reg_wdata, m_data);
        end
      end
    end
  end

  typedef struct {
    bit          lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    bit          av;
    logic [4:0]  ard;
    logic [31:0] adat;
    bit          busy;
    bit          elr;
    bit          ear;
    int          ecnt;
  } vec_t;

  vec_t tbl[15];
  int   wr_addr[5];

  task automatic idle();
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
  endtask

  initial begin
    // lv lrd ldat  av ard adat  busy  lr ar cnt_after
    tbl[0]  = '{1, 3, 32'h11, 1, 3, 32'h22, 0, 1, 1, 2};
    tbl[1]  = '{0, 0, 0,      0, 0, 0,      0, 1, 1, 1};
    tbl[2]  = '{0, 0, 0,      0, 0, 0,      0, 1, 1, 0};
    tbl[3]  = '{0, 0, 0,      1, 0, 32'hFFFFFFFF, 0, 1, 1, 0};
    tbl[4]  = '{0, 0, 0,      1, 7, 32'h70, 1, 1, 1, 1};
    tbl[5]  = '{0, 0, 0,      1, 8, 32'h80, 1, 1, 1, 2};
    tbl[6]  = '{0, 0, 0,      1, 9, 32'h90, 1, 1, 1, 3};
    tbl[7]  = '{1, 10, 32'hA0, 1, 11, 32'hB0, 1, 1, 0, 4};
    tbl[8]  = '{0, 0, 0,      1, 12, 32'hC0, 1, 0, 0, 4};
    tbl[9]  = '{0, 0, 0,      1, 12, 32'hC0, 0, 0, 0, 3};
    tbl[10] = '{0, 0, 0,      1, 12, 32'hC0, 0, 1, 1, 3};
    tbl[11] = '{0, 0, 0,      0, 0, 0,      0, 1, 1, 2};
    tbl[12] = '{0, 0, 0,      0, 0, 0,      0, 1, 1, 1};
    tbl[13] = '{0, 0, 0,      0, 0, 0,      0, 1, 1, 0};
    tbl[14] = '{0, 0, 0,      0, 0, 0,      0, 1, 1, 0};
    wr_addr = '{1, 2, 3, 4, 6};

    rst = 1'b1;
    rf_busy = 1'b0;
    chk_addr = '0;
    idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("release_lsu_ready", lsu_ready, 1);
    chk("release_alu_ready", alu_ready, 1);

    // Single ALU result: write appears exactly two cycles after acceptance.
    @(posedge clk); #1;
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF; chk_addr = 5;
    @(negedge clk);
    chk("t2_wen_N", reg_wen, 1);
    chk("t2_pend_N", chk_pending, 0);
    @(posedge clk); #1; idle();
    @(negedge clk);
    chk("t2_wen_N1", reg_wen, 1);
    chk("t2_pend_N1", chk_pending, 1);
    chk("t2_count_N1", q_count, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_wen_N2", reg_wen, 0);
    chk("t2_waddr_N2", reg_waddr, 5);
    chk("t2_wdata_N2", reg_wdata, 32'hDEADBEEF);
    chk("t2_pend_N2", chk_pending, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_wen_N3", reg_wen, 1);
    chk("t2_pend_N3", chk_pending, 0);

    // Vector table: readiness during the cycle, occupancy after the edge.
    chk_addr = 3;
    @(posedge clk); #1;
    for (int i = 0; i < 15; i++) begin
      lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_data = tbl[i].ldat;
      alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].adat;
      rf_busy   = tbl[i].busy;
      @(negedge clk);
      chk($sformatf("vec%0d_lsu_ready", i), lsu_ready, tbl[i].elr);
      chk($sformatf("vec%0d_alu_ready", i), alu_ready, tbl[i].ear);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_count", i), q_count, tbl[i].ecnt);
    end
    idle(); rf_busy = 0;

    // r0 result: handshake completes, nothing queued or written.
    chk_addr = 0;
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFFFFFF;
    @(negedge clk);
    chk("t4_alu_ready", alu_ready, 1);
    @(posedge clk); #1; idle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_count", q_count, 0);
      chk("t4_wen", reg_wen, 1);
      chk("t4_pending", chk_pending, 0);
      @(posedge clk); #1;
    end

    // Fill under rf_busy, hold a fifth result, then drain back-to-back.
    rf_busy = 1;
    for (int k = 0; k < 4; k++) begin
      alu_valid = 1; alu_rd = 5'(k + 1); alu_data = 32'h100 + 32'(k);
      @(posedge clk); #1;
    end
    alu_valid = 1; alu_rd = 6; alu_data = 32'h600;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t5_full_count", q_count, 4);
      chk("t5_full_alu_ready", alu_ready, 0);
      chk("t5_full_lsu_ready", lsu_ready, 0);
      @(posedge clk); #1;
    end
    rf_busy = 0;
    @(negedge clk);
    chk("t5_held_alu_ready", alu_ready, 0);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) chk("t5_fifth_alu_ready", alu_ready, 1);
      chk("t5_drain_wen", reg_wen, 0);
      chk("t5_drain_waddr", reg_waddr, wr_addr[k]);
      @(posedge clk); #1;
      if (k == 0) idle();
    end
    @(negedge clk);
    chk("t5_done_wen", reg_wen, 1);

    // Reset mid-burst discards queued entries.
    @(posedge clk); #1;
    rf_busy = 1;
    alu_valid = 1; alu_rd = 20; alu_data = 32'h20;
    @(posedge clk); #1;
    alu_rd = 21; alu_data = 32'h21;
    lsu_valid = 1; lsu_rd = 22; lsu_data = 32'h22;
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("t1_rst_wen", reg_wen, 1);
    chk("t1_rst_waddr", reg_waddr, 0);
    chk("t1_rst_count", q_count, 0);
    chk("t1_rst_lsu_ready", lsu_ready, 0);
    chk("t1_rst_alu_ready", alu_ready, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0; idle(); rf_busy = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t1_post_wen", reg_wen, 1);
      chk("t1_post_count", q_count, 0);
      chk("t1_post_lsu_ready", lsu_ready, 1);
      chk("t1_post_alu_ready", alu_ready, 1);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
